// File: rtl/if_branch_prediction_bimodal_pkg.sv
// Shared definitions for the bimodal branch predictor: counter encodings,
// reset state and default table sizing.
package if_branch_prediction_bimodal_pkg;

    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } bp_ctr_e;

    localparam bp_ctr_e     CtrReset       = CtrWt;
    localparam int unsigned IdxBitsDefault = 4;
    localparam int unsigned MissCntW       = 16;

    // Direction implied by a counter value: upper half of the range means taken.
    function automatic logic ctr_taken(input bp_ctr_e ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/if_branch_prediction_bimodal_bp_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module bp_sat_counter2
    import if_branch_prediction_bimodal_pkg::*;
(
    input  bp_ctr_e ctr_i,
    input  logic    take_i,
    output bp_ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (ctr_i)
            CtrSnt: ctr_o = take_i ? CtrWnt : CtrSnt;
            CtrWnt: ctr_o = take_i ? CtrWt  : CtrSnt;
            CtrWt:  ctr_o = take_i ? CtrSt  : CtrWnt;
            CtrSt:  ctr_o = take_i ? CtrSt  : CtrWt;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/if_branch_prediction_bimodal.sv
// Bimodal branch direction predictor: a flop table of 2-bit counters indexed by
// PC, trained one cycle after branch resolution with a bypass into lookup.
module if_branch_prediction_bimodal
    import if_branch_prediction_bimodal_pkg::*;
#(
    parameter int unsigned IDX_BITS = IdxBitsDefault
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pred_enable,
    input  logic [31:0]         pc_fetch,
    input  logic                pc_jmp_feedback,
    input  logic                pc_jmp_take,
    input  logic [31:0]         pc_stash_base,
    output logic                pc_prediction_take,
    output logic [MissCntW-1:0] bp_miss_count
);

    localparam int unsigned Entries = 1 << IDX_BITS;

    bp_ctr_e               table_q [Entries];
    logic                  upd_valid_q, upd_valid_d;
    logic [IDX_BITS-1:0]   upd_idx_q, upd_idx_d;
    logic                  upd_take_q, upd_take_d;
    logic [MissCntW-1:0]   miss_cnt_q, miss_cnt_d;

    logic [IDX_BITS-1:0]   fetch_idx;
    bp_ctr_e               upd_ctr_cur;
    bp_ctr_e               upd_ctr_next;
    bp_ctr_e               fetch_ctr;
    logic                  upd_miss;

    assign fetch_idx = pc_fetch[IDX_BITS+1:2];

    // PC bits outside the index field are intentionally ignored (aliasing).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_fetch[31:IDX_BITS+2], pc_fetch[1:0],
                              pc_stash_base[31:IDX_BITS+2], pc_stash_base[1:0]};

    // Write-stage read port; the same next value also feeds the lookup bypass.
    assign upd_ctr_cur = table_q[upd_idx_q];

    bp_sat_counter2 u_sat_counter (
        .ctr_i  (upd_ctr_cur),
        .take_i (upd_take_q),
        .ctr_o  (upd_ctr_next)
    );

    assign upd_miss = upd_valid_q && (ctr_taken(upd_ctr_cur) != upd_take_q);

    always_comb begin
        upd_valid_d = pc_jmp_feedback;
        upd_idx_d   = pc_stash_base[IDX_BITS+1:2];
        upd_take_d  = pc_jmp_take;
        miss_cnt_d  = miss_cnt_q;
        if (upd_miss && (miss_cnt_q != {MissCntW{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    // Lookup uses only registered update state, never the raw feedback inputs.
    always_comb begin
        fetch_ctr = table_q[fetch_idx];
        if (upd_valid_q && (upd_idx_q == fetch_idx)) begin
            fetch_ctr = upd_ctr_next;
        end
    end

    assign pc_prediction_take = reset || !pred_enable || ctr_taken(fetch_ctr);
    assign bp_miss_count      = miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_take_q  <= 1'b0;
            miss_cnt_q  <= '0;
            for (int i = 0; i < Entries; i++) begin
                table_q[i] <= CtrReset;
            end
        end else begin
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_take_q  <= upd_take_d;
            miss_cnt_q  <= miss_cnt_d;
            if (upd_valid_q) begin
                table_q[upd_idx_q] <= upd_ctr_next;
            end
        end
    end

endmodule

// File: tb/tb_if_branch_prediction_bimodal.sv
// Scoreboard bench for the bimodal predictor: a behavioural model queues the
// expected prediction and miss count each cycle, compared mid-cycle.
module tb_if_branch_prediction_bimodal;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_enable;
    logic [31:0] pc_fetch;
    logic        pc_jmp_feedback;
    logic        pc_jmp_take;
    logic [31:0] pc_stash_base;
    logic        pc_prediction_take;
    logic [15:0] bp_miss_count;

    if_branch_prediction_bimodal #(.IDX_BITS(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .pred_enable        (pred_enable),
        .pc_fetch           (pc_fetch),
        .pc_jmp_feedback    (pc_jmp_feedback),
        .pc_jmp_take        (pc_jmp_take),
        .pc_stash_base      (pc_stash_base),
        .pc_prediction_take (pc_prediction_take),
        .bp_miss_count      (bp_miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pred;
        logic [15:0] miss;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: counters as integers 0..3, pending update, miss count.
    int   m_tbl [16];
    bit   m_pv;
    int   m_pidx;
    bit   m_ptake;
    int   m_miss;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_step(input int v, input bit take);
        if (take) return (v == 3) ? 3 : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = 2;
        m_pv   = 0;
        m_pidx = 0;
        m_ptake = 0;
        m_miss = 0;
    endtask

    task automatic step(input bit rst, input bit en, input logic [31:0] fetch,
                        input bit fb, input bit take, input logic [31:0] base,
                        input string tag);
        exp_t e;
        exp_t got;
        int   fidx;
        int   v;
        reset           = rst;
        pred_enable     = en;
        pc_fetch        = fetch;
        pc_jmp_feedback = fb;
        pc_jmp_take     = take;
        pc_stash_base   = base;
        fidx = int'(fetch[5:2]);
        if (m_pv && m_pidx == fidx) v = sat_step(m_tbl[fidx], m_ptake);
        else v = m_tbl[fidx];
        e.tag  = tag;
        e.pred = (rst || !en) ? 1'b1 : (v >= 2);
        e.miss = 16'(m_miss);
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check_eq({got.tag, "_pred"}, 32'(pc_prediction_take), 32'(got.pred));
        check_eq({got.tag, "_miss"}, 32'(bp_miss_count), 32'(got.miss));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_pv) begin
                if ((m_tbl[m_pidx] >= 2) != m_ptake && m_miss < 65535) m_miss++;
                m_tbl[m_pidx] = sat_step(m_tbl[m_pidx], m_ptake);
            end
            m_pv    = fb;
            m_pidx  = int'(base[5:2]);
            m_ptake = take;
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] fetch, input string tag);
        step(0, 1, fetch, 0, 0, 32'h0, tag);
    endtask

    initial begin
        logic [31:0] addrs [6];
        addrs = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h10c, 32'h1f4};
        reset = 1'b1;
        pred_enable = 1'b1;
        pc_fetch = '0;
        pc_jmp_feedback = 1'b0;
        pc_jmp_take = 1'b0;
        pc_stash_base = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset with feedback present: feedback must be discarded.
        step(1, 1, 32'h100, 1, 0, 32'h100, "rst_fb");
        idle(32'h100, "post_rst");

        step(0, 1, 32'h100, 1, 0, 32'h100, "nt_fb");
        idle(32'h100, "nt_bypass");
        idle(32'h100, "nt_written");

        step(1, 1, 32'h0, 0, 0, 32'h0, "rst2");
        for (int i = 0; i < 4; i++) step(0, 1, 32'h104, 1, 0, 32'h104, "seq_nt");
        for (int i = 0; i < 3; i++) step(0, 1, 32'h104, 1, 1, 32'h104, "seq_t");
        idle(32'h104, "seq_end0");
        idle(32'h104, "seq_end1");

        step(1, 1, 32'h0, 0, 0, 32'h0, "rst3");
        step(0, 1, 32'h140, 1, 0, 32'h100, "alias_a");
        step(0, 1, 32'h140, 1, 0, 32'h140, "alias_b");
        idle(32'h140, "alias_c");
        idle(32'h100, "alias_d");

        step(1, 1, 32'h0, 0, 0, 32'h0, "rst4");
        step(0, 1, 32'h108, 1, 0, 32'h108, "dis_nt0");
        step(0, 1, 32'h108, 1, 0, 32'h108, "dis_nt1");
        idle(32'h108, "dis_idle");
        step(0, 0, 32'h108, 0, 0, 32'h0, "dis_off");
        step(0, 0, 32'h108, 1, 0, 32'h108, "dis_train");
        step(0, 1, 32'h108, 0, 0, 32'h0, "dis_on");

        step(1, 1, 32'h0, 0, 0, 32'h0, "rst5");
        step(0, 1, 32'h100, 1, 0, 32'h100, "drop_fb");
        step(1, 1, 32'h100, 0, 0, 32'h0, "drop_rst");
        idle(32'h100, "drop_chk");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                 addrs[$urandom_range(0, 5)], 1'($urandom), 1'($urandom),
                 addrs[$urandom_range(0, 5)], "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
